usb_buf_loopback: RTL

//  Application-side endpoint engine for the usb2/usb3 device cores' user buffer interface.

---
 rtl/usb_buf_pkg.sv | 16 +
 rtl/usb_buf_loopback.sv | 114 +++++++++++
 2 files changed

// File: rtl/usb_buf_pkg.sv
// Shared definitions for the USB user-buffer loopback engine.
package usb_buf_pkg;

  localparam int BUF_ADDR_W = 9;
  localparam int BUF_LEN_W  = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_IN = 3'd1,
    ST_COPY    = 3'd2,
    ST_COMMIT  = 3'd3,
    ST_ARM     = 3'd4,
    ST_DRAIN   = 3'd5
  } buf_state_e;

endpackage

// File: rtl/usb_buf_loopback.sv
// Loopback engine: drains an OUT packet, XORs each byte, refills IN, commits, re-arms OUT.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for enable & buf_out_hasdata; latches clamped length
// WAIT_IN | waiting for the IN buffer to be free
// COPY    | streaming rd_idx 0..len-1, writes trail reads by one cycle
// COMMIT  | commit request held until buf_in_commit_ack
// ARM     | OUT re-arm request held until buf_out_arm_ack; stats update
// DRAIN   | waiting for the core to drop buf_out_hasdata
module usb_buf_loopback
  import usb_buf_pkg::*;
#(
  parameter logic [7:0] XOR_MASK = 8'h00,
  parameter int         MAX_LEN  = 512
) (
  input  logic                  ext_clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  buf_out_hasdata,
  input  logic [BUF_LEN_W-1:0]  buf_out_len,
  output logic [BUF_ADDR_W-1:0] buf_out_addr,
  input  logic [7:0]            buf_out_q,
  output logic                  buf_out_arm,
  input  logic                  buf_out_arm_ack,
  input  logic                  buf_in_ready,
  output logic [BUF_ADDR_W-1:0] buf_in_addr,
  output logic [7:0]            buf_in_data,
  output logic                  buf_in_wren,
  output logic                  buf_in_commit,
  output logic [BUF_LEN_W-1:0]  buf_in_commit_len,
  input  logic                  buf_in_commit_ack,
  output logic                  busy,
  output logic [15:0]           stat_pkt_count,
  output logic [31:0]           stat_byte_count
);

  localparam logic [BUF_LEN_W-1:0] MAX_LEN_V = BUF_LEN_W'(MAX_LEN);

  buf_state_e             state, state_nxt;
  logic [BUF_LEN_W-1:0]   len_q;
  logic [BUF_LEN_W-1:0]   len_clamped;
  logic [BUF_LEN_W-1:0]   rd_idx;
  logic                   rd_active;
  logic                   pipe_vld;
  logic [BUF_ADDR_W-1:0]  pipe_addr;
  logic                   start;

  assign len_clamped = (buf_out_len > MAX_LEN_V) ? MAX_LEN_V : buf_out_len;
  assign rd_active   = (state == ST_COPY) && (rd_idx < len_q);
  assign start       = (state == ST_IDLE) && enable && buf_out_hasdata;

  // State register
  always_ff @(posedge ext_clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt         = state;
    buf_in_commit     = 1'b0;
    buf_in_commit_len = '0;
    buf_out_arm       = 1'b0;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_WAIT_IN;
      ST_WAIT_IN: if (buf_in_ready) state_nxt = (len_q != '0) ? ST_COPY : ST_COMMIT;
      ST_COPY:    if (rd_idx == len_q) state_nxt = ST_COMMIT;
      ST_COMMIT: begin
        buf_in_commit     = 1'b1;
        buf_in_commit_len = len_q;
        if (buf_in_commit_ack) state_nxt = ST_ARM;
      end
      ST_ARM: begin
        buf_out_arm = 1'b1;
        if (buf_out_arm_ack) state_nxt = ST_DRAIN;
      end
      ST_DRAIN:   if (!buf_out_hasdata) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Length latch, read index, one-stage copy pipeline and statistics
  always_ff @(posedge ext_clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q           <= '0;
      rd_idx          <= '0;
      pipe_vld        <= 1'b0;
      pipe_addr       <= '0;
      stat_pkt_count  <= '0;
      stat_byte_count <= '0;
    end else begin
      if (start) len_q <= len_clamped;
      if (state == ST_WAIT_IN) rd_idx <= '0;
      else if (rd_active)      rd_idx <= rd_idx + 1'b1;
      pipe_vld  <= rd_active;
      pipe_addr <= rd_idx[BUF_ADDR_W-1:0];
      if ((state == ST_ARM) && buf_out_arm_ack) begin
        stat_pkt_count  <= stat_pkt_count + 16'd1;
        stat_byte_count <= stat_byte_count + {22'd0, len_q};
      end
    end
  end

  // Buffer-side datapath; everything forced to 0 outside active cycles
  always_comb begin
    buf_out_addr = rd_active ? rd_idx[BUF_ADDR_W-1:0] : '0;
    buf_in_wren  = pipe_vld;
    buf_in_addr  = pipe_vld ? pipe_addr : '0;
    buf_in_data  = pipe_vld ? (buf_out_q ^ XOR_MASK) : 8'h00;
    busy         = (state != ST_IDLE);
  end

endmodule
